deck_shuffler: RTL and testbench

Generates a pseudo-randomly shuffled 52-card deck and streams it, one card per handshake, to the dealing/setup stage that builds the stock, talon and tableau piles. It sits directly upstream of the setup logic in the solitaire top level. The shuffle is a hardware Fisher–Yates pass driven by a seeded 16-bit LFSR, so a given seed always deals the same game.

---
 rtl/deck_shuffler.sv | 141 ++++++++++++++
 tb/tb_deck_shuffler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/deck_shuffler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deck_shuffler: LFSR-driven Fisher-Yates shuffle of a 52-card deck,         |
// | streamed one card per valid/ready handshake. Option: SHUFFLER_BYPASS_EN    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module deck_shuffler #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] card_out,
  output logic       card_valid,
  input  logic       card_ready,
  output logic       card_last,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [5:0]  LAST_IDX  = 6'd51;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  i_q, i_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  deck_q [52];
  logic [5:0]  deck_d [52];
  logic [6:0]  card_out_q, card_out_d;
  logic        card_valid_q, card_valid_d;
  logic        card_last_q, card_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Sorted order: rank cycles fastest, suit advances every 13 cards.
  function automatic logic [5:0] sorted_card(input int n);
    sorted_card = {4'(n % 13 + 1), 2'(n / 13)};
  endfunction

`ifndef SHUFFLER_BYPASS_EN
  logic [5:0] draw;
  assign draw = lfsr_q[5:0];
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    k_d     = k_q;
    deck_d  = deck_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int n = 0; n < 52; n++) deck_d[n] = sorted_card(n);
          k_d = 6'd0;
`ifdef SHUFFLER_BYPASS_EN
          state_d = S_STREAM;
`else
          i_d     = LAST_IDX;
          state_d = S_SHUFFLE;
`endif
        end
      end
`ifndef SHUFFLER_BYPASS_EN
      S_SHUFFLE: begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        // Draws above i are rejected rather than folded, keeping the shuffle unbiased.
        if (draw <= i_q) begin
          deck_d[i_q]  = deck_q[draw];
          deck_d[draw] = deck_q[i_q];
          i_d          = i_q - 6'd1;
          if (i_q == 6'd1) begin
            state_d = S_STREAM;
            k_d     = 6'd0;
          end
        end
      end
`endif
      S_STREAM: begin
        if (card_valid_q && card_ready) begin
          if (k_q == LAST_IDX) state_d = S_DONE;
          else                 k_d     = k_q + 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with state_q.
    card_valid_d = (state_d == S_STREAM);
    card_out_d   = card_valid_d ? {deck_d[k_d], 1'b0} : 7'h00;
    card_last_d  = card_valid_d && (k_d == LAST_IDX);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_INIT;
      i_q          <= 6'd0;
      k_q          <= 6'd0;
      card_out_q   <= 7'h00;
      card_valid_q <= 1'b0;
      card_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      i_q          <= i_d;
      k_q          <= k_d;
      card_out_q   <= card_out_d;
      card_valid_q <= card_valid_d;
      card_last_q  <= card_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign card_out   = card_out_q;
  assign card_valid = card_valid_q;
  assign card_last  = card_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_deck_shuffler.sv
`default_nettype none
// tb_deck_shuffler: table of deal scenarios checked against a behavioural
// shuffle model via a card scoreboard; a second instance uses SEED=0.
module tb_deck_shuffler;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] MASK   = 16'hB400;
  localparam int          BUDGET = 1500;
  localparam int          NDEALS = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       card_ready = 1'b0;
  logic [6:0] card_out, card_out0;
  logic       card_valid, card_valid0, card_last, card_last0;
  logic       busy, busy0, done, done0;

  always #5 clk = ~clk;

  deck_shuffler #(.SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start(start), .card_out(card_out),
    .card_valid(card_valid), .card_ready(card_ready), .card_last(card_last),
    .busy(busy), .done(done)
  );

  deck_shuffler #(.SEED(16'h0000)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .card_out(card_out0),
    .card_valid(card_valid0), .card_ready(card_ready), .card_last(card_last0),
    .busy(busy0), .done(done0)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  m_deck [52];
  int          m_cycles;
  logic [6:0]  sb [$];
  logic [5:0]  seq [NDEALS][52];

  typedef struct {
    int mode;       // 0 ready=1, 1 stall 10 cycles, 2 random ready, 3 reset at card 20
    bit mid_start;
    bit pre_reset;
    bit cmp_first;
    int exp_cards;
    int exp_done;
  } deal_t;

  deal_t tbl [NDEALS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_deal();
    int i;
    logic [5:0] r, t;
    for (int n = 0; n < 52; n++) m_deck[n] = 6'(((n % 13) + 1) * 4 + (n / 13));
    m_cycles = 0;
`ifndef SHUFFLER_BYPASS_EN
    i = 51;
    while (i >= 1 && m_cycles < 10000) begin
      r = m_lfsr[5:0];
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ MASK) : (m_lfsr >> 1);
      m_cycles++;
      if (int'(r) <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[r]; m_deck[r] = t;
        i--;
      end
    end
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {card_out, card_valid, card_last, busy, done}, 32'h0);
    check({name, "_seed0"}, {card_out0, card_valid0, card_last0, busy0, done0}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_vals");
    rst = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic run_deal(input deal_t d, input int idx);
    int ncards = 0, ndone = 0, lat = -1, cnt = 0, stall = 0;
    int last_xfer_at = -10, done_at = -10, distinct = 0;
    bit prev_hold = 1'b0, finished = 1'b0;
    bit seen [64];
    logic [6:0] prev_card, exp;
    logic prev_last;
    for (int n = 0; n < 64; n++) seen[n] = 1'b0;
    if (d.pre_reset) do_reset();
    model_deal();
    sb.delete();
    for (int n = 0; n < 52; n++) sb.push_back({m_deck[n], 1'b0});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    check("busy_rise", busy, 1);
    while (!finished && cnt < BUDGET) begin
      if (prev_hold) begin
        check("hold_valid", card_valid, 1);
        check("hold_card", card_out, prev_card);
        check("hold_last", card_last, prev_last);
      end
      if (card_valid && lat < 0) lat = cnt;
      if (done) begin
        ndone++;
        check("done_timing", cnt, last_xfer_at + 1);
        done_at = cnt;
      end
      if (cnt == done_at + 1) begin
        check("busy_fall", busy, 0);
        finished = 1'b1;
      end
      start = d.mid_start && (cnt == 20 || (lat > 0 && cnt == lat + 5));
      case (d.mode)
        1: begin
          if (card_valid && ncards == 5 && stall < 10) begin
            card_ready = 1'b0;
            stall++;
          end else card_ready = 1'b1;
        end
        2:       card_ready = 1'($urandom_range(0, 1));
        default: card_ready = 1'b1;
      endcase
      if (d.mode == 3 && ncards == 20) begin
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("abort_async");
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = SEED;
        sb.delete();
        finished = 1'b1;
      end else if (card_valid && card_ready) begin
        if (sb.size() == 0) begin
          check("extra_card", ncards, 52);
        end else begin
          exp = sb.pop_front();
          check("card", card_out, exp);
          check("card_seed0", {card_valid0, card_out0}, {1'b1, exp});
          check("last", card_last, sb.size() == 0);
          seen[card_out[6:1]] = 1'b1;
          if (ncards < 52) seq[idx][ncards] = card_out[6:1];
          ncards++;
          if (sb.size() == 0) last_xfer_at = cnt;
        end
      end
      prev_hold = card_valid && !card_ready;
      prev_card = card_out;
      prev_last = card_last;
      if (!finished) begin
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    card_ready = 1'b0;
    check("deal_finished", finished, 1);
    check("card_count", ncards, d.exp_cards);
    check("done_count", ndone, d.exp_done);
    if (d.exp_cards == 52) begin
      check("first_valid_latency", lat, m_cycles + 1);
      for (int n = 0; n < 64; n++)
        if (seen[n] && (n >> 2) >= 1 && (n >> 2) <= 13) distinct++;
      check("permutation", distinct, 52);
    end
    if (d.mid_start) begin
      repeat (2) @(negedge clk);
      check("start_ignored_idle", busy, 0);
    end
    if (d.cmp_first) begin
      int diffs = 0;
      for (int n = 0; n < 52; n++) if (seq[idx][n] !== seq[0][n]) diffs++;
      check("repeat_after_reset", diffs, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int diffs;
    tbl[0] = '{0, 1'b0, 1'b1, 1'b0, 52, 1};
    tbl[1] = '{0, 1'b1, 1'b0, 1'b0, 52, 1};
    tbl[2] = '{1, 1'b0, 1'b0, 1'b0, 52, 1};
    tbl[3] = '{2, 1'b0, 1'b0, 1'b0, 52, 1};
    tbl[4] = '{3, 1'b0, 1'b0, 1'b0, 20, 0};
    tbl[5] = '{0, 1'b0, 1'b0, 1'b1, 52, 1};
    tbl[6] = '{2, 1'b0, 1'b1, 1'b1, 52, 1};

    #3;
    check_idle_outputs("power_on_reset");
    m_lfsr = SEED;

    for (int t = 0; t < NDEALS; t++) run_deal(tbl[t], t);

    diffs = 0;
    for (int n = 0; n < 52; n++) if (seq[1][n] !== seq[0][n]) diffs++;
`ifdef SHUFFLER_BYPASS_EN
    check("bypass_same_deal", diffs, 0);
    check("bypass_card0", {seq[0][0], 1'b0}, 7'h08);
    check("bypass_card13", {seq[0][13], 1'b0}, 7'h0A);
    check("bypass_card51", {seq[0][51], 1'b0}, 7'h6E);
`else
    check("back_to_back_differ", diffs != 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
